// File: rtl/usb_pkt_rx_pkg.sv
// Shared types and constants for the USB packet receiver: PID codes, FSM states,
// CRC mode select and pkt_err bit positions.
package usb_pkt_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOK,
    S_DATA,
    S_EOP,
    S_DRAIN
  } state_t;

  typedef enum logic {
    CRC_MODE_5,
    CRC_MODE_16
  } crc_mode_t;

  // pkt_err = {RX, LEN, CRC, PID}
  localparam int unsigned ERR_PID = 0;
  localparam int unsigned ERR_CRC = 1;
  localparam int unsigned ERR_LEN = 2;
  localparam int unsigned ERR_RX  = 3;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_pkt_rx_crc.sv
// Combinational byte-wide USB CRC update (CRC5 in crc_in[4:0] or full CRC16),
// bits consumed LSB first as they appear on the wire.
module usb_crc
  import usb_pkt_rx_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mode == CRC_MODE_16) begin
        fb = data[i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      end else begin
        fb     = data[i] ^ c[4];
        c[4:0] = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : '0);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_pkt_rx.sv
// USB packet receiver: frames the usb_rx byte stream, checks PID/CRC5/CRC16/length
// and decodes tokens, handshakes and DATA payloads. Macro USB_PKT_RX_SOF_EN enables SOF decode.
module usb_pkt_rx
  import usb_pkt_rx_pkg::*;
#(
  parameter int unsigned MAX_DATA = 8
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic        tok_valid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic        sof_valid,
  output logic [10:0] frame,
  output logic        hs_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        pkt_done,
  output logic [3:0]  pkt_err
);

  localparam int unsigned CW = $clog2(MAX_DATA + 4);
  localparam logic [CW-1:0] CNT_TOK  = CW'(2);
  localparam logic [CW-1:0] EMIT_END = CW'(MAX_DATA + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DATA + 3);

  state_t        state_q, state_d;
  logic          act_q;
  logic [3:0]    pid_q, pid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d, crc_nxt;
  logic [3:0]    err_q, err_d, err_eop;
  logic [7:0]    b1_q, b1_d;
  logic [2:0]    hi_q, hi_d;
  logic [7:0]    d0_q, d0_d, d1_q, d1_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [3:0]    pkt_err_q, pkt_err_d;
  logic          out_valid_q, out_valid_d, tok_valid_q, tok_valid_d;
  logic          hs_valid_q, hs_valid_d, pkt_done_q, pkt_done_d;
  logic          crc_mode;
`ifdef USB_PKT_RX_SOF_EN
  logic [10:0]   frame_q, frame_d;
  logic          sof_valid_q, sof_valid_d;
`endif

  assign crc_mode = (state_q == S_TOK) ? CRC_MODE_5 : CRC_MODE_16;

  usb_crc u_crc (
    .mode    (crc_mode),
    .crc_in  (crc_q),
    .data    (rx_data),
    .crc_out (crc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    err_d       = err_q;
    b1_d        = b1_q;
    hi_d        = hi_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    out_data_d  = out_data_q;
    pkt_err_d   = pkt_err_q;
    out_valid_d = 1'b0;
    tok_valid_d = 1'b0;
    hs_valid_d  = 1'b0;
    pkt_done_d  = 1'b0;
    err_eop     = '0;
`ifdef USB_PKT_RX_SOF_EN
    frame_d     = frame_q;
    sof_valid_d = 1'b0;
`endif

    if (state_q == S_IDLE) begin
      if (rx_active && !act_q) begin
        state_d = S_PID;
        cnt_d   = '0;
        err_d   = '0;
        crc_d   = '1;
      end
    end else begin
      if (rx_error) begin
        err_d[ERR_RX] = 1'b1;
        state_d       = S_DRAIN;
      end else if (rx_valid) begin
        case (state_q)
          S_PID: begin
            pid_d = rx_data[3:0];
            if (rx_data[3:0] != ~rx_data[7:4]) begin
              err_d[ERR_PID] = 1'b1;
              state_d        = S_DRAIN;
            end else begin
              case (rx_data[3:0])
                PID_OUT, PID_IN, PID_SETUP, PID_SOF: state_d = S_TOK;
                PID_DATA0, PID_DATA1:                state_d = S_DATA;
                PID_ACK, PID_NAK, PID_STALL:         state_d = S_EOP;
                default: begin
                  err_d[ERR_PID] = 1'b1;
                  state_d        = S_DRAIN;
                end
              endcase
            end
          end
          S_TOK: begin
            crc_d = crc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == '0) begin
              b1_d = rx_data;
            end else if (cnt_q == CW'(1)) begin
              hi_d = rx_data[2:0];
            end else begin
              err_d[ERR_LEN] = 1'b1;
              state_d        = S_DRAIN;
            end
          end
          S_DATA: begin
            crc_d = crc_nxt;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            d0_d = rx_data;
            d1_d = d0_q;
            // d1 holds the byte two positions back, so CRC bytes never surface
            if (cnt_q >= CNT_TOK && cnt_q < EMIT_END) begin
              out_valid_d = 1'b1;
              out_data_d  = d1_q;
            end
            if (cnt_q >= EMIT_END) err_d[ERR_LEN] = 1'b1;
          end
          S_EOP:   err_d[ERR_LEN] = 1'b1;
          default: ;
        endcase
      end

      // End of packet is judged on the post-byte values so a final byte is counted first
      if (!rx_active && act_q) begin
        err_eop = err_d;
        case (state_d)
          S_PID: err_eop[ERR_LEN] = 1'b1;
          S_TOK: begin
            if (cnt_d != CNT_TOK)                   err_eop[ERR_LEN] = 1'b1;
            else if (crc_d[4:0] != CRC5_RESIDUAL)   err_eop[ERR_CRC] = 1'b1;
          end
          S_DATA: begin
            if (cnt_d < CNT_TOK)                    err_eop[ERR_LEN] = 1'b1;
            else if (crc_d != CRC16_RESIDUAL)       err_eop[ERR_CRC] = 1'b1;
          end
          default: ;
        endcase
        pkt_done_d = 1'b1;
        pkt_err_d  = err_eop;
        if (err_eop == '0) begin
          if (state_d == S_EOP) begin
            hs_valid_d = 1'b1;
          end else if (state_d == S_TOK) begin
            if (pid_d != PID_SOF) begin
              tok_valid_d = 1'b1;
              addr_d      = b1_d[6:0];
              endp_d      = {hi_d, b1_d[7]};
            end
`ifdef USB_PKT_RX_SOF_EN
            else begin
              sof_valid_d = 1'b1;
              frame_d     = {hi_d, b1_d};
            end
`endif
          end
        end
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    act_q <= rx_active;
    if (!reset) begin
      state_q     <= S_IDLE;
      pid_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= '1;
      err_q       <= '0;
      b1_q        <= '0;
      hi_q        <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      out_data_q  <= '0;
      pkt_err_q   <= '0;
      out_valid_q <= 1'b0;
      tok_valid_q <= 1'b0;
      hs_valid_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
`ifdef USB_PKT_RX_SOF_EN
      frame_q     <= '0;
      sof_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      b1_q        <= b1_d;
      hi_q        <= hi_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      out_data_q  <= out_data_d;
      pkt_err_q   <= pkt_err_d;
      out_valid_q <= out_valid_d;
      tok_valid_q <= tok_valid_d;
      hs_valid_q  <= hs_valid_d;
      pkt_done_q  <= pkt_done_d;
`ifdef USB_PKT_RX_SOF_EN
      frame_q     <= frame_d;
      sof_valid_q <= sof_valid_d;
`endif
    end
  end

  assign pid       = pid_q;
  assign tok_valid = tok_valid_q;
  assign addr      = addr_q;
  assign endp      = endp_q;
  assign hs_valid  = hs_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
`ifdef USB_PKT_RX_SOF_EN
  assign sof_valid = sof_valid_q;
  assign frame     = frame_q;
`else
  assign sof_valid = 1'b0;
  assign frame     = '0;
`endif

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Directed byte-level bench for usb_pkt_rx; expected values are hand-computed
// (including the CRC5 bytes for the IN token and the SOF frame).
`timescale 1ns/1ps
module tb_usb_pkt_rx;

  logic        clk = 1'b0;
  logic        reset, rx_valid, rx_active, rx_error;
  logic [7:0]  rx_data;
  logic [3:0]  pid, endp, pkt_err;
  logic [6:0]  addr;
  logic [10:0] frame;
  logic [7:0]  out_data;
  logic        tok_valid, sof_valid, hs_valid, out_valid, pkt_done;

  usb_pkt_rx #(.MAX_DATA(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .tok_valid(tok_valid),
    .addr(addr), .endp(endp), .sof_valid(sof_valid), .frame(frame),
    .hs_valid(hs_valid), .out_data(out_data), .out_valid(out_valid),
    .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  always #21 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, done_cyc = 0, fall_cyc = 0;
  int n_tok = 0, n_sof = 0, n_hs = 0, n_done = 0;
  int b_tok, b_sof, b_hs, b_done, b_out;
  logic [7:0] cap[$];
  logic [7:0] pkt[$];
  logic [7:0] exp_pl[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) cap.push_back(out_data);
    if (tok_valid) n_tok++;
    if (sof_valid) n_sof++;
    if (hs_valid)  n_hs++;
    if (pkt_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic begin_pkt();
    b_tok = n_tok; b_sof = n_sof; b_hs = n_hs; b_done = n_done; b_out = cap.size();
    rx_active = 1'b1;
    repeat (3) tick();
  endtask

  task automatic end_pkt(input string tag);
    rx_active = 1'b0;
    fall_cyc  = cyc;
    repeat (4) tick();
    check({tag, "_done"}, n_done - b_done, 1);
    check({tag, "_done_lat"}, done_cyc - fall_cyc, 1);
  endtask

  task automatic send_pkt(input string tag);
    begin_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
    end_pkt(tag);
  endtask

  task automatic check_payload(input string tag);
    logic [31:0] got;
    check({tag, "_nout"}, cap.size() - b_out, exp_pl.size());
    foreach (exp_pl[i]) begin
      got = (b_out + i < cap.size()) ? {24'h0, cap[b_out + i]} : 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp_pl[i]});
    end
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_active = 1'b0; rx_error = 1'b0; rx_data = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_pid", pid, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_pulses", {tok_valid, sof_valid, hs_valid, out_valid, pkt_done}, 0);
    check("rst_fields", {addr, endp, frame, out_data}, 0);

    pkt = {8'h2D, 8'h00, 8'h10};
    send_pkt("setup");
    check("setup_tok", n_tok - b_tok, 1);
    check("setup_pid", pid, 4'hD);
    check("setup_addr", addr, 0);
    check("setup_endp", endp, 0);
    check("setup_err", pkt_err, 0);

    pkt = {8'h69, 8'h15, 8'hEF};
    send_pkt("in");
    check("in_tok", n_tok - b_tok, 1);
    check("in_pid", pid, 4'h9);
    check("in_addr", addr, 7'h15);
    check("in_endp", endp, 4'hE);
    check("in_err", pkt_err, 0);

    exp_pl = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    pkt = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send_pkt("d0");
    check_payload("d0");
    check("d0_err", pkt_err, 0);
    check("d0_pid", pid, 4'h3);

    pkt = {8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
    send_pkt("d0bad");
    check_payload("d0bad");
    check("d0bad_err", pkt_err, 4'b0010);

    pkt = {8'hD2};
    send_pkt("ack");
    check("ack_hs", n_hs - b_hs, 1);
    check("ack_pid", pid, 4'h2);
    check("ack_err", pkt_err, 0);

    pkt = {8'hD3};
    send_pkt("badpid");
    check("badpid_hs", n_hs - b_hs, 0);
    check("badpid_err", pkt_err, 4'b0001);
    check("badpid_pid", pid, 4'h3);

    exp_pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pkt = {8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hAA, 8'hBB};
    send_pkt("long");
    check_payload("long");
    check("long_len", pkt_err[2], 1);

    begin_pkt();
    send_byte(8'h2D);
    send_byte(8'h00);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    repeat (3) tick();
    send_byte(8'h10);
    end_pkt("rxerr");
    check("rxerr_rx", pkt_err[3], 1);
    check("rxerr_tok", n_tok - b_tok, 0);

    pkt = {8'hA5, 8'h23, 8'hF1};
    send_pkt("sof");
    check("sof_err", pkt_err, 0);
    check("sof_tok", n_tok - b_tok, 0);
`ifdef USB_PKT_RX_SOF_EN
    check("sof_valid", n_sof - b_sof, 1);
    check("sof_frame", frame, 11'h123);
`else
    check("sof_valid", n_sof - b_sof, 0);
    check("sof_frame", frame, 0);
`endif

    // Final byte and falling rx_active in the same cycle
    begin_pkt();
    rx_data = 8'h5A; rx_valid = 1'b1; rx_active = 1'b0;
    fall_cyc = cyc;
    tick();
    rx_valid = 1'b0;
    repeat (4) tick();
    check("nak_done", n_done - b_done, 1);
    check("nak_done_lat", done_cyc - fall_cyc, 1);
    check("nak_hs", n_hs - b_hs, 1);
    check("nak_err", pkt_err, 0);

    pkt = {8'hC3, 8'h80};
    send_pkt("short");
    check("short_err", pkt_err, 4'b0100);

    pkt = {8'h69, 8'h15, 8'hEF, 8'h00};
    send_pkt("tok4");
    check("tok4_err", pkt_err, 4'b0100);
    check("tok4_tok", n_tok - b_tok, 0);

    pkt = {8'hD2, 8'h00};
    send_pkt("ackx");
    check("ackx_err", pkt_err, 4'b0100);
    check("ackx_hs", n_hs - b_hs, 0);

    begin_pkt();
    send_byte(8'hC3);
    send_byte(8'h80);
    send_byte(8'h06);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    rx_active = 1'b0;
    repeat (4) tick();
    check("midrst_done", n_done - b_done, 0);
    check("midrst_out", cap.size() - b_out, 0);
    check("midrst_pid", pid, 0);

    pkt = {8'h2D, 8'h00, 8'h10};
    send_pkt("after");
    check("after_tok", n_tok - b_tok, 1);
    check("after_pid", pid, 4'hD);
    check("after_err", pkt_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
